matrix_scan_ctrl: RTL and testbench
===================================

Name: matrix_scan_ctrl

Overview:
- Row-scan sequencer for the 32x32 dot-matrix display inside the pong core.
- Fetches one row of pixels per scan slot from the framebuffer over a req/ack handshake.
- Shifts the row serially into the column shift registers (CSDI/CCLK), then latches it (LE).
- Advances a one-hot row token through the row shift register (RSDI/RCLK) and gates display output with OEB.

Parameters:
ROWS, 32, number of matrix rows; row counter width is clog2(ROWS).
COLS, 32, pixels per row; width of fb_data.
CLK_DIV, 2, clk32mhz cycles per CCLK/RCLK/LE half-period; must be >= 1.
ON_TIME, 256, clk32mhz cycles OEB is held low per row.

Ports:
clk32mhz  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
enable  in  1  scan enable.
fb_req  out  1  framebuffer read request.
fb_row  out  clog2(ROWS)  row address; stable while fb_req=1.
fb_ack  in  1  framebuffer read acknowledge; fb_data valid in the same cycle.
fb_data  in  COLS  row pixels; bit COLS-1 is shifted first.
CSDI  out  1  column serial data.
CCLK  out  1  column shift clock.
LE  out  1  column latch enable, active high.
RSDI  out  1  row serial data (row token).
RCLK  out  1  row shift clock.
OEB  out  1  output enable, active low; 1 = blanked.
frame_done  out  1  one-cycle pulse at the end of the last row.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; row=0.
  - fb_req, CSDI, CCLK, LE, RSDI, RCLK, frame_done = 0; OEB = 1.
  - A reset mid-row returns to these values immediately; no partial row is completed.
- IDLE: OEB=1. When enable=1, go to FETCH with row=0.
- FETCH:
  - fb_req=1, fb_row=row.
  - On the cycle fb_ack=1, capture fb_data into the shift buffer; fb_req=0 from the next cycle; go to SHIFT.
  - fb_ack while fb_req=0 is ignored.
- SHIFT (previously latched row stays displayed; OEB keeps its prior value):
  - COLS bits, MSB first.
  - Each bit: CSDI driven and CCLK=0 for CLK_DIV cycles, then CCLK=1 for CLK_DIV cycles.
  - Buffer shifts left on the CCLK falling transition.
  - Duration: exactly 2*CLK_DIV*COLS cycles; CCLK=0 on exit.
- BLANK: 1 cycle, OEB=1.
- LATCH:
  - LE=1 and RCLK=1 together for CLK_DIV cycles, then both 0 for CLK_DIV cycles.
  - RSDI = (row==0) for the whole state, so the token enters on row 0 and shifts on every other row.
- DISPLAY: OEB=0 for ON_TIME cycles, then:
  - row==ROWS-1: frame_done=1 for one cycle; row wraps to 0.
  - otherwise: row increments.
  - enable=1: go to FETCH. enable=0: OEB=1, row=0, go to IDLE.
- enable is sampled only in IDLE and on the last DISPLAY cycle; deassertion elsewhere completes the current row.
- Row period (fetch completed with ack on the first req cycle): 1 + 2*CLK_DIV*COLS + 1 + 2*CLK_DIV + ON_TIME. Defaults: 1+128+1+4+256 = 390 cycles.
- fb_ack latency is unbounded; the block waits indefinitely in FETCH with the previous row still displayed.

Optional Feature:
- Macro: MATRIX_SCAN_BRIGHTNESS_EN.
- With the macro:
  - Extra input port brightness [1:0].
  - Sampled on entry to DISPLAY.
  - OEB=0 only for the first ((brightness+1)*ON_TIME)/4 cycles of DISPLAY, and 1 for the remainder.
  - DISPLAY length is unchanged.
- Without the macro: no port; OEB=0 for all of DISPLAY.

Test Plan:
- Reset: hold reset=0 with enable=1 -> OEB=1; all other outputs 0; fb_req=0.
- Single row, defaults: enable=1, fb_ack one cycle after fb_req, fb_data=32'hA5000001 -> CCLK rising-edge samples of CSDI read 1,0,1,0,0,1,0,1,…,1 (32 bits); LE high for 2 cycles; RSDI=1 during LATCH; OEB=0 for exactly 256 cycles.
- Full frame: 32 rows with immediate ack -> fb_row runs 0..31; frame_done pulses once, 32*390 cycles after the first fb_req (ack in the same cycle as req); next fb_row=0 with RSDI=1 on its latch.
- Stalled ack: hold fb_ack=0 for 1000 cycles in row 5 -> fb_req stays high; fb_row=5 stable; OEB stays 0 (row 4 still lit); no CCLK edges.
- Mid-operation: deassert enable during SHIFT of row 3 -> row 3 completes its DISPLAY, then IDLE with OEB=1. Separately, assert reset during LATCH -> LE=RCLK=0 and OEB=1 in the same cycle.
- With MATRIX_SCAN_BRIGHTNESS_EN, brightness=2'b01 -> OEB=0 for 128 cycles, then 1 for 128 cycles per row.

Source files
------------

// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer for the 32x32 dot-matrix: fetch row, shift columns, latch, display.
// Optional MATRIX_SCAN_BRIGHTNESS_EN adds a brightness[1:0] input that shortens the OEB-low window.
module matrix_scan_ctrl #(
  parameter int ROWS    = 32,
  parameter int COLS    = 32,
  parameter int CLK_DIV = 2,
  parameter int ON_TIME = 256
) (
  input  logic                    clk32mhz,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    fb_req,
  output logic [$clog2(ROWS)-1:0] fb_row,
  input  logic                    fb_ack,
  input  logic [COLS-1:0]         fb_data,
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  input  logic [1:0]              brightness,
`endif
  output logic                    CSDI,
  output logic                    CCLK,
  output logic                    LE,
  output logic                    RSDI,
  output logic                    RCLK,
  output logic                    OEB,
  output logic                    frame_done
);

  localparam int RW    = $clog2(ROWS);
  localparam int PH    = 2 * CLK_DIV;
  localparam int CMAX  = (ON_TIME > PH) ? ON_TIME : PH;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int BIT_W = $clog2(COLS);

  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PH - 1);
  localparam logic [CNT_W-1:0] DIV_C    = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TIME - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(COLS - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SHIFT   = 3'd2,
    BLANK   = 3'd3,
    LATCH   = 3'd4,
    DISPLAY = 3'd5
  } state_t;

  state_t           state;
  logic [RW-1:0]    row;
  logic [COLS-2:0]  sbuf;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] on_len_nxt;
  logic [BIT_W-1:0] bit_idx;

  assign cnt_nxt = cnt + CNT_W'(1);
  assign fb_row  = row;

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  assign on_len_nxt = CNT_W'(((32'(brightness) + 32'd1) * ON_TIME) / 4);
`else
  assign on_len_nxt = CNT_W'(ON_TIME);
`endif

  // Handshake: fb_req rises on entry to FETCH and holds (with fb_row stable) until
  // the cycle fb_ack=1 is seen; fb_data is captured in that same cycle. fb_ack with
  // fb_req=0 has no effect.
  always_ff @(posedge clk32mhz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      row        <= '0;
      sbuf       <= '0;
      cnt        <= '0;
      on_len     <= '0;
      bit_idx    <= '0;
      fb_req     <= 1'b0;
      CSDI       <= 1'b0;
      CCLK       <= 1'b0;
      LE         <= 1'b0;
      RSDI       <= 1'b0;
      RCLK       <= 1'b0;
      OEB        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          OEB <= 1'b1;
          if (enable) begin
            row    <= '0;
            fb_req <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (fb_ack) begin
            sbuf    <= fb_data[COLS-2:0];
            CSDI    <= fb_data[COLS-1];
            CCLK    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            fb_req  <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Each bit: CLK_DIV cycles low, CLK_DIV high; next bit appears on the fall.
          if (cnt == PH_LAST) begin
            cnt     <= '0;
            CCLK    <= 1'b0;
            sbuf    <= {sbuf[COLS-3:0], 1'b0};
            CSDI    <= sbuf[COLS-2];
            bit_idx <= bit_idx + BIT_W'(1);
            if (bit_idx == BIT_LAST) begin
              CSDI  <= 1'b0;
              OEB   <= 1'b1;
              state <= BLANK;
            end
          end else begin
            cnt  <= cnt_nxt;
            CCLK <= (cnt_nxt >= DIV_C);
          end
        end
        BLANK: begin
          LE    <= 1'b1;
          RCLK  <= 1'b1;
          RSDI  <= (row == '0);
          cnt   <= '0;
          state <= LATCH;
        end
        LATCH: begin
          if (cnt == PH_LAST) begin
            LE     <= 1'b0;
            RCLK   <= 1'b0;
            RSDI   <= 1'b0;
            cnt    <= '0;
            on_len <= on_len_nxt;
            OEB    <= (on_len_nxt == '0);
            state  <= DISPLAY;
          end else begin
            cnt  <= cnt_nxt;
            LE   <= (cnt_nxt < DIV_C);
            RCLK <= (cnt_nxt < DIV_C);
          end
        end
        DISPLAY: begin
          if (cnt == ON_LAST) begin
            cnt        <= '0;
            frame_done <= (row == ROW_LAST);
            row        <= (row == ROW_LAST) ? '0 : row + RW'(1);
            if (enable) begin
              fb_req <= 1'b1;
              state  <= FETCH;
            end else begin
              OEB   <= 1'b1;
              row   <= '0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt_nxt;
            OEB <= (cnt_nxt >= on_len);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: row-level observations compared against timing and data
// predicted from the scan rules; builds with or without MATRIX_SCAN_BRIGHTNESS_EN.
module tb_matrix_scan_ctrl;

  localparam int ROWS    = 32;
  localparam int COLS    = 32;
  localparam int CLK_DIV = 2;
  localparam int ON_TIME = 256;
  localparam int RW      = $clog2(ROWS);

  // Row window, counted in cycles after the ack edge (i=1 is the first SHIFT cycle).
  localparam int SHIFT_LEN  = 2 * CLK_DIV * COLS;
  localparam int BLANK_I    = SHIFT_LEN + 1;
  localparam int LATCH_I    = SHIFT_LEN + 2;
  localparam int DISP_I     = LATCH_I + 2 * CLK_DIV;
  localparam int LAST_I     = DISP_I + ON_TIME - 1;
  localparam int ROW_PERIOD = 1 + SHIFT_LEN + 1 + 2 * CLK_DIV + ON_TIME;

  logic            clk32mhz = 1'b0;
  logic            reset    = 1'b0;
  logic            enable   = 1'b0;
  logic            fb_ack   = 1'b0;
  logic [COLS-1:0] fb_data  = '0;
  logic            fb_req;
  logic [RW-1:0]   fb_row;
  logic            CSDI, CCLK, LE, RSDI, RCLK, OEB, frame_done;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  logic [1:0]      brightness = 2'd3;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fd_count    = 0;
  int fd_cyc      = 0;
  int timeouts    = 0;
  logic [COLS-1:0] exp_q[$];

  typedef struct {
    logic            timeout;
    int              wait_cyc;
    int              req_cyc;
    logic [RW-1:0]   row;
    int              stall_bad;
    int              stall_cclk;
    int              stall_oeb_hi;
    int              req_bad;
    logic [COLS-1:0] bits;
    int              rises;
    logic            blank_oeb;
    logic            blank_cclk;
    int              rclk_bad;
    int              le_hi;
    int              le_first;
    int              rsdi_bad;
    int              oeb_low;
    int              oeb_first;
    int              oeb_last;
  } row_obs_t;

  matrix_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .ON_TIME(ON_TIME)
  ) dut (
    .clk32mhz   (clk32mhz),
    .reset      (reset),
    .enable     (enable),
    .fb_req     (fb_req),
    .fb_row     (fb_row),
    .fb_ack     (fb_ack),
    .fb_data    (fb_data),
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .CSDI       (CSDI),
    .CCLK       (CCLK),
    .LE         (LE),
    .RSDI       (RSDI),
    .RCLK       (RCLK),
    .OEB        (OEB),
    .frame_done (frame_done)
  );

  // Clock and cycle count
  always #5 clk32mhz = ~clk32mhz;
  always @(posedge clk32mhz) cyc <= cyc + 1;

  always @(negedge clk32mhz) begin
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_cyc = cyc;
    end
  end

  // Reference: number of OEB-low cycles at the start of each DISPLAY.
  function automatic int exp_on_len();
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    return ((int'(brightness) + 1) * ON_TIME) / 4;
`else
    return ON_TIME;
`endif
  endfunction

  // Driver/monitor for one row: waits for fb_req, acks after ack_delay cycles,
  // then records what the display pins do over the whole row.
  task automatic run_row(input int ack_delay, input logic [COLS-1:0] data,
                         input int drop_at, output row_obs_t o);
    logic prev_cclk;
    o = '{default: 0};
    if (timeouts > 2) begin
      o.timeout = 1'b1;
      return;
    end
    do begin
      @(negedge clk32mhz);
      o.wait_cyc++;
    end while (fb_req !== 1'b1 && o.wait_cyc < 1500);
    if (fb_req !== 1'b1) begin
      timeouts++;
      vectors++;
      miscompares++;
      $display("FAIL row_wait: fb_req=%b after %0d cycles, required 1", fb_req, o.wait_cyc);
      o.timeout = 1'b1;
      return;
    end
    o.req_cyc = cyc;
    o.row     = fb_row;
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge clk32mhz);
      if (fb_req !== 1'b1 || fb_row !== o.row) o.stall_bad++;
      if (CCLK !== 1'b0) o.stall_cclk++;
      if (OEB !== 1'b0) o.stall_oeb_hi++;
    end
    fb_ack  = 1'b1;
    fb_data = data;
    exp_q.push_back(data);
    prev_cclk = 1'b0;
    for (int i = 1; i <= LAST_I; i++) begin
      @(negedge clk32mhz);
      fb_ack  = (i >= 2 && i <= SHIFT_LEN) ? 1'($urandom_range(0, 1)) : 1'b0;
      fb_data = COLS'($urandom);
      if (i == drop_at) enable = 1'b0;
      if (fb_req !== 1'b0) o.req_bad++;
      if (CCLK === 1'b1 && prev_cclk === 1'b0) begin
        o.bits = {o.bits[COLS-2:0], CSDI};
        o.rises++;
      end
      prev_cclk = CCLK;
      if (i == BLANK_I) begin
        o.blank_oeb  = OEB;
        o.blank_cclk = CCLK;
      end
      if (LE !== RCLK) o.rclk_bad++;
      if (LE === 1'b1) begin
        o.le_hi++;
        if (o.le_first == 0) o.le_first = i;
      end
      if (i >= LATCH_I && i < DISP_I && RSDI !== (o.row == '0)) o.rsdi_bad++;
      if (i >= BLANK_I && OEB === 1'b0) begin
        o.oeb_low++;
        if (o.oeb_first == 0) o.oeb_first = i;
        o.oeb_last = i;
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk32mhz);
    vectors++;
    if ({fb_req, CSDI, CCLK, LE, RSDI, RCLK, OEB, frame_done} !== 8'b0000_0010) begin
      miscompares++;
      $display("FAIL reset_outputs: got req,csdi,cclk,le,rsdi,rclk,oeb,fd=%b required 00000010",
               {fb_req, CSDI, CCLK, LE, RSDI, RCLK, OEB, frame_done});
    end
    vectors++;
    if (fb_row !== '0) begin
      miscompares++;
      $display("FAIL reset_row: got %0d required 0", fb_row);
    end
  endtask

  task automatic test_single_row();
    row_obs_t o;
    logic [COLS-1:0] exp;
    int on;
    reset = 1'b1;
    on = exp_on_len();
    run_row(1, 32'hA500_0001, 0, o);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++;
    if (o.row !== 0) begin miscompares++; $display("FAIL single_row: got %0d required 0", o.row); end
    vectors++;
    if (o.bits !== exp || o.rises !== COLS) begin
      miscompares++;
      $display("FAIL single_bits: got %h (%0d edges) required %h (%0d edges)", o.bits, o.rises, exp, COLS);
    end
    vectors++;
    if (o.le_hi !== CLK_DIV || o.le_first !== LATCH_I || o.rclk_bad !== 0) begin
      miscompares++;
      $display("FAIL single_latch: got le_hi=%0d at %0d rclk_bad=%0d required %0d at %0d 0",
               o.le_hi, o.le_first, o.rclk_bad, CLK_DIV, LATCH_I);
    end
    vectors++;
    if (o.rsdi_bad !== 0) begin miscompares++; $display("FAIL single_rsdi: got %0d bad cycles required 0", o.rsdi_bad); end
    vectors++;
    if (o.blank_oeb !== 1'b1 || o.blank_cclk !== 1'b0) begin
      miscompares++;
      $display("FAIL single_blank: got oeb=%b cclk=%b required 1 0", o.blank_oeb, o.blank_cclk);
    end
    vectors++;
    if (o.oeb_low !== on || o.oeb_first !== DISP_I || o.oeb_last !== DISP_I + on - 1) begin
      miscompares++;
      $display("FAIL single_oeb: got %0d low [%0d..%0d] required %0d [%0d..%0d]",
               o.oeb_low, o.oeb_first, o.oeb_last, on, DISP_I, DISP_I + on - 1);
    end
    vectors++;
    if (o.req_bad !== 0) begin miscompares++; $display("FAIL single_req_drop: got %0d req cycles required 0", o.req_bad); end
  endtask

  task automatic test_enable_drop();
    row_obs_t o;
    logic [COLS-1:0] exp;
    int bad;
    for (int r = 1; r <= 3; r++) begin
      run_row($urandom_range(0, 6), COLS'($urandom), (r == 3) ? $urandom_range(2, SHIFT_LEN - 1) : 0, o);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (o.row !== RW'(r) || o.bits !== exp) begin
        miscompares++;
        $display("FAIL drop_row%0d: got row %0d data %h required row %0d data %h", r, o.row, o.bits, r, exp);
      end
      vectors++;
      if (o.oeb_low !== exp_on_len()) begin
        miscompares++;
        $display("FAIL drop_oeb%0d: got %0d low cycles required %0d", r, o.oeb_low, exp_on_len());
      end
    end
    bad = 0;
    repeat (30) begin
      @(negedge clk32mhz);
      if (fb_req !== 1'b0 || OEB !== 1'b1) bad++;
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL drop_idle: got %0d active cycles required 0", bad); end
  endtask

  task automatic test_full_frame();
    row_obs_t o;
    logic [COLS-1:0] exp;
    int r0, prev, fd0;
    enable = 1'b1;
    fd0  = fd_count;
    r0   = 0;
    prev = 0;
    for (int r = 0; r < ROWS; r++) begin
      run_row(0, COLS'($urandom), 0, o);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (r == 0) r0 = o.req_cyc;
      vectors++;
      if (o.row !== RW'(r) || o.bits !== exp) begin
        miscompares++;
        $display("FAIL frame_row%0d: got row %0d data %h required row %0d data %h", r, o.row, o.bits, r, exp);
      end
      if (r > 0) begin
        vectors++;
        if (o.req_cyc - prev !== ROW_PERIOD) begin
          miscompares++;
          $display("FAIL frame_period%0d: got %0d cycles required %0d", r, o.req_cyc - prev, ROW_PERIOD);
        end
      end
      prev = o.req_cyc;
    end
    run_row(0, COLS'($urandom), 0, o);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++;
    if (fd_count - fd0 !== 1 || fd_cyc - r0 !== ROWS * ROW_PERIOD) begin
      miscompares++;
      $display("FAIL frame_done: got %0d pulses at +%0d required 1 at +%0d", fd_count - fd0, fd_cyc - r0, ROWS * ROW_PERIOD);
    end
    vectors++;
    if (o.row !== 0 || o.rsdi_bad !== 0 || o.le_hi !== CLK_DIV || o.bits !== exp) begin
      miscompares++;
      $display("FAIL frame_wrap: got row %0d rsdi_bad %0d le %0d required row 0 rsdi_bad 0 le %0d",
               o.row, o.rsdi_bad, o.le_hi, CLK_DIV);
    end
  endtask

  task automatic test_stalled_ack();
    row_obs_t o;
    logic [COLS-1:0] exp;
    for (int r = 1; r <= 5; r++) begin
      run_row((r == 5) ? 1000 : 0, COLS'($urandom), 0, o);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (o.row !== RW'(r) || o.bits !== exp) begin
        miscompares++;
        $display("FAIL stall_row%0d: got row %0d data %h required row %0d data %h", r, o.row, o.bits, r, exp);
      end
    end
    vectors++;
    if (o.stall_bad !== 0 || o.stall_cclk !== 0 || o.stall_oeb_hi !== 0) begin
      miscompares++;
      $display("FAIL stall_hold: got req/row bad %0d cclk %0d oeb_hi %0d required 0 0 0",
               o.stall_bad, o.stall_cclk, o.stall_oeb_hi);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    w = 0;
    do begin
      @(negedge clk32mhz);
      w++;
    end while (fb_req !== 1'b1 && w < 1500);
    fb_ack  = 1'b1;
    fb_data = COLS'($urandom);
    for (int i = 1; i <= LATCH_I; i++) begin
      @(negedge clk32mhz);
      fb_ack = 1'b0;
    end
    vectors++;
    if (LE !== 1'b1 || RCLK !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: got le=%b rclk=%b required 1 1", LE, RCLK);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({LE, RCLK, OEB, fb_req, CCLK, RSDI} !== 6'b001000) begin
      miscompares++;
      $display("FAIL midrst_now: got le,rclk,oeb,req,cclk,rsdi=%b required 001000",
               {LE, RCLK, OEB, fb_req, CCLK, RSDI});
    end
    repeat (3) @(negedge clk32mhz);
    reset = 1'b1;
  endtask

  task automatic test_random();
    row_obs_t o;
    logic [COLS-1:0] exp;
    int on;
    for (int n = 0; n < 8; n++) begin
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
      brightness = 2'($urandom_range(0, 3));
`endif
      on = exp_on_len();
      run_row($urandom_range(0, 8), COLS'($urandom), 0, o);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (o.row !== RW'(n) || o.bits !== exp) begin
        miscompares++;
        $display("FAIL rand_row%0d: got row %0d data %h required row %0d data %h", n, o.row, o.bits, n, exp);
      end
      vectors++;
      if (o.oeb_low !== on || o.oeb_first !== DISP_I || o.oeb_last !== DISP_I + on - 1) begin
        miscompares++;
        $display("FAIL rand_oeb%0d: got %0d low [%0d..%0d] required %0d [%0d..%0d]",
                 n, o.oeb_low, o.oeb_first, o.oeb_last, on, DISP_I, DISP_I + on - 1);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_enable_drop();
    test_full_frame();
    test_stalled_ack();
    test_reset_mid();
    test_random();
    repeat (5) @(negedge clk32mhz);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
